// File: rtl/connect4_pkg.sv
// Shared Connect-4 types: board geometry, cell encoding, board array and drop FSM states.
// Also used by the win checker and the VGA renderer.
package connect4_pkg;

  localparam int ROWS = 6;
  localparam int COLS = 7;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  // Row 0 is the top row and column 0 is the left column.
  typedef logic [0:ROWS-1][0:COLS-1][1:0] board_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    CHECK,
    EVAL,
    OVER
  } drop_state_t;

  function automatic logic [1:0] next_player(input logic [1:0] p);
    return (p == P1) ? P2 : P1;
  endfunction

endpackage

// File: rtl/drop_controller.sv
// Connect-4 board owner: applies gravity to column drops, hands each move to the
// win checker and decides win, draw or turn change.
//
// state | meaning
// IDLE  | waiting for a drop request
// SCAN  | walking the column upward, one row per cycle, looking for the lowest empty cell
// CHECK | piece committed; check_en pulses to the win checker
// EVAL  | win checker result sampled; drop_ack pulses
// OVER  | game finished (win or draw); only new_game or rst leave
module drop_controller #(
  parameter int         ROWS         = 6,
  parameter int         COLS         = 7,
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                new_game,
  input  logic                                drop_req,
  input  logic [2:0]                          drop_col,
  input  logic                                win_flag,
  input  logic [1:0]                          winner_id,
  output logic [0:ROWS-1][0:COLS-1][1:0]      board,
  output logic                                check_en,
  output logic [1:0]                          current_player,
  output logic                                busy,
  output logic                                drop_ack,
  output logic                                drop_err,
  output logic [2:0]                          last_row,
  output logic [2:0]                          last_col,
  output logic [5:0]                          move_count,
  output logic                                game_over,
  output logic [1:0]                          winner,
  output logic                                draw_flag
);
  import connect4_pkg::*;

  localparam logic [2:0] COL_LIMIT = 3'(COLS);
  localparam logic [2:0] BOTTOM    = 3'(ROWS - 1);
  localparam logic [5:0] CELLS     = 6'(ROWS * COLS);

  drop_state_t state, state_next;
  logic [2:0]  row_idx;
  logic [2:0]  col_q;
  logic        col_valid;
  logic        cell_empty;
  logic        board_full;

  assign col_valid  = drop_col < COL_LIMIT;
  assign cell_empty = board[row_idx][col_q] == EMPTY;
  assign board_full = move_count == CELLS;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    check_en   = 1'b0;
    drop_ack   = 1'b0;
    busy       = 1'b0;
    game_over  = 1'b0;
    case (state)
      IDLE: begin
        if (drop_req && col_valid) state_next = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (cell_empty)          state_next = CHECK;
        else if (row_idx == '0)  state_next = IDLE;
      end
      CHECK: begin
        busy       = 1'b1;
        check_en   = 1'b1;
        state_next = EVAL;
      end
      EVAL: begin
        busy     = 1'b1;
        drop_ack = 1'b1;
        if (win_flag || board_full) state_next = OVER;
        else                        state_next = IDLE;
      end
      OVER: begin
        game_over = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (new_game) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      board          <= '0;
      current_player <= FIRST_PLAYER;
      drop_err       <= 1'b0;
      last_row       <= '0;
      last_col       <= '0;
      move_count     <= '0;
      winner         <= '0;
      draw_flag      <= 1'b0;
      row_idx        <= '0;
      col_q          <= '0;
    end else if (new_game) begin
      board          <= '0;
      current_player <= FIRST_PLAYER;
      drop_err       <= 1'b0;
      last_row       <= '0;
      last_col       <= '0;
      move_count     <= '0;
      winner         <= '0;
      draw_flag      <= 1'b0;
      row_idx        <= '0;
      col_q          <= '0;
    end else begin
      drop_err <= 1'b0;
      case (state)
        IDLE: begin
          if (drop_req) begin
            if (col_valid) begin
              col_q   <= drop_col;
              row_idx <= BOTTOM;
            end else begin
              drop_err <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (cell_empty) begin
            board[row_idx][col_q] <= current_player;
            last_row              <= row_idx;
            last_col              <= col_q;
            move_count            <= move_count + 6'd1;
          end else if (row_idx == '0) begin
            drop_err <= 1'b1;
          end else begin
            row_idx <= row_idx - 3'd1;
          end
        end
        EVAL: begin
          // A win on the final cell counts as a win, not a draw.
          if (win_flag)        winner         <= winner_id;
          else if (board_full) draw_flag      <= 1'b1;
          else                 current_player <= next_player(current_player);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_drop_controller.sv
// Directed bench for drop_controller: gravity, latency, column full, bad column,
// win, draw, new_game and asynchronous reset mid-scan.
module tb_drop_controller;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       new_game;
  logic                       drop_req;
  logic [2:0]                 drop_col;
  logic                       win_flag;
  logic [1:0]                 winner_id;
  logic [0:5][0:6][1:0]       board;
  logic                       check_en;
  logic [1:0]                 current_player;
  logic                       busy;
  logic                       drop_ack;
  logic                       drop_err;
  logic [2:0]                 last_row;
  logic [2:0]                 last_col;
  logic [5:0]                 move_count;
  logic                       game_over;
  logic [1:0]                 winner;
  logic                       draw_flag;

  logic [0:5][0:6][1:0]       exp_board;
  int                         heights [0:6];
  int                         tests  = 0;
  int                         failed = 0;
  int                         ack_cyc;
  int                         chk_cyc;
  int                         err_cyc;
  int                         saw_chk;

  drop_controller dut (
    .clk(clk), .rst(rst), .new_game(new_game), .drop_req(drop_req), .drop_col(drop_col),
    .win_flag(win_flag), .winner_id(winner_id), .board(board), .check_en(check_en),
    .current_player(current_player), .busy(busy), .drop_ack(drop_ack), .drop_err(drop_err),
    .last_row(last_row), .last_col(last_col), .move_count(move_count), .game_over(game_over),
    .winner(winner), .draw_flag(draw_flag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    exp_board = '0;
    for (int c = 0; c < 7; c++) heights[c] = 0;
  endtask

  task automatic place(input int col, input logic [1:0] p);
    exp_board[5 - heights[col]][col] = p;
    heights[col]++;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    clear_model();
  endtask

  // Accepted drop: records the cycle (counted from the request cycle) of check_en and drop_ack.
  task automatic do_drop(input int col, input int k, input logic wf, input logic [1:0] wid);
    win_flag  = wf;
    winner_id = wid;
    drop_req  = 1'b1;
    drop_col  = 3'(col);
    step();
    drop_req = 1'b0;
    ack_cyc  = 0;
    chk_cyc  = 0;
    for (int n = 1; n <= 20 && ack_cyc == 0; n++) begin
      if (check_en) chk_cyc = n;
      if (drop_ack) ack_cyc = n;
      else          step();
    end
    chk("ack_latency", 96'(ack_cyc), 96'(k + 3));
    chk("check_en_cycle", 96'(chk_cyc), 96'(k + 2));
    step();
    win_flag  = 1'b0;
    winner_id = 2'b00;
  endtask

  // Rejected drop: records the cycle of drop_err and whether check_en ever rose.
  task automatic do_bad_drop(input int col);
    drop_req = 1'b1;
    drop_col = 3'(col);
    step();
    drop_req = 1'b0;
    err_cyc  = 0;
    saw_chk  = 0;
    for (int n = 1; n <= 20 && err_cyc == 0; n++) begin
      if (check_en) saw_chk = 1;
      if (drop_err) err_cyc = n;
      else          step();
    end
  endtask

  initial begin
    rst = 1'b0; new_game = 1'b0; drop_req = 1'b0; drop_col = 3'd0;
    win_flag = 1'b0; winner_id = 2'b00;
    clear_model();
    #23;
    chk("rst_board", 96'(board), 96'(0));
    chk("rst_player", 96'(current_player), 96'(2'b01));
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_moves", 96'(move_count), 96'(0));
    chk("rst_flags", 96'({check_en, drop_ack, drop_err, game_over, draw_flag, winner}), 96'(0));
    chk("rst_last", 96'({last_row, last_col}), 96'(0));
    rst = 1'b1;
    step();

    // First move into an empty column 3.
    do_drop(3, 0, 1'b0, 2'b00);
    exp_board[5][3] = 2'b01;
    chk("first_board", 96'(board), 96'(exp_board));
    chk("first_player", 96'(current_player), 96'(2'b10));
    chk("first_moves", 96'(move_count), 96'(1));
    chk("first_last", 96'({last_row, last_col}), 96'({3'd5, 3'd3}));
    chk("first_idle", 96'(busy), 96'(0));

    // Fill column 0, then overfill it.
    pulse_new_game();
    chk("ng_board", 96'(board), 96'(0));
    chk("ng_player", 96'(current_player), 96'(2'b01));
    for (int i = 0; i < 6; i++) begin
      do_drop(0, i, 1'b0, 2'b00);
      place(0, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    chk("col0_board", 96'(board), 96'(exp_board));
    chk("col0_last", 96'({last_row, last_col}), 96'({3'd0, 3'd0}));
    do_bad_drop(0);
    chk("full_err_cycle", 96'(err_cyc), 96'(7));
    chk("full_no_check", 96'(saw_chk), 96'(0));
    step();
    chk("full_err_pulse", 96'(drop_err), 96'(0));
    chk("full_board", 96'(board), 96'(exp_board));
    chk("full_moves", 96'(move_count), 96'(6));
    chk("full_player", 96'(current_player), 96'(2'b01));

    // Out-of-range column.
    do_bad_drop(7);
    chk("badcol_err_cycle", 96'(err_cyc), 96'(1));
    chk("badcol_busy", 96'(busy), 96'(0));
    chk("badcol_no_check", 96'(saw_chk), 96'(0));
    step();
    chk("badcol_err_pulse", 96'(drop_err), 96'(0));
    chk("badcol_board", 96'(board), 96'(exp_board));

    // P1 wins with cols 0..3 on the bottom row.
    pulse_new_game();
    do_drop(0, 0, 1'b0, 2'b00); place(0, 2'b01);
    do_drop(0, 1, 1'b0, 2'b00); place(0, 2'b10);
    do_drop(1, 0, 1'b0, 2'b00); place(1, 2'b01);
    do_drop(1, 1, 1'b0, 2'b00); place(1, 2'b10);
    do_drop(2, 0, 1'b0, 2'b00); place(2, 2'b01);
    do_drop(2, 1, 1'b0, 2'b00); place(2, 2'b10);
    do_drop(3, 0, 1'b1, 2'b01); place(3, 2'b01);
    chk("win_over", 96'(game_over), 96'(1));
    chk("win_winner", 96'(winner), 96'(2'b01));
    chk("win_draw", 96'(draw_flag), 96'(0));
    chk("win_busy", 96'(busy), 96'(0));
    chk("win_player", 96'(current_player), 96'(2'b01));
    chk("win_board", 96'(board), 96'(exp_board));
    do_bad_drop(4);
    chk("over_no_err", 96'(err_cyc), 96'(0));
    chk("over_no_check", 96'(saw_chk), 96'(0));
    chk("over_board", 96'(board), 96'(exp_board));
    chk("over_moves", 96'(move_count), 96'(7));
    chk("over_held", 96'({game_over, winner}), 96'({1'b1, 2'b01}));
    new_game = 1'b1; drop_req = 1'b1; drop_col = 3'd2;
    step();
    new_game = 1'b0; drop_req = 1'b0;
    clear_model();
    step();
    chk("ng_drop_busy", 96'(busy), 96'(0));
    chk("ng_clear_board", 96'(board), 96'(0));
    chk("ng_clear_state", 96'({game_over, winner, draw_flag, move_count}), 96'(0));
    chk("ng_clear_player", 96'(current_player), 96'(2'b01));

    // Fill the whole board with no win reported.
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) begin
        do_drop(c, r, 1'b0, 2'b00);
        place(c, ((c * 6 + r) % 2 == 0) ? 2'b01 : 2'b10);
      end
    chk("draw_flag", 96'(draw_flag), 96'(1));
    chk("draw_over", 96'(game_over), 96'(1));
    chk("draw_winner", 96'(winner), 96'(2'b00));
    chk("draw_moves", 96'(move_count), 96'(42));
    chk("draw_board", 96'(board), 96'(exp_board));
    chk("draw_player", 96'(current_player), 96'(2'b10));

    // Async reset while scanning a column holding three pieces.
    pulse_new_game();
    do_drop(4, 0, 1'b0, 2'b00);
    do_drop(4, 1, 1'b0, 2'b00);
    do_drop(4, 2, 1'b0, 2'b00);
    drop_req = 1'b1; drop_col = 3'd4;
    step();
    drop_col = 3'd5;
    chk("scan_busy", 96'(busy), 96'(1));
    step();
    drop_req = 1'b0;
    chk("scan_busy2", 96'(busy), 96'(1));
    chk("scan_moves", 96'(move_count), 96'(3));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_board", 96'(board), 96'(0));
    chk("arst_player", 96'(current_player), 96'(2'b01));
    chk("arst_idle", 96'({busy, check_en, drop_ack, drop_err, move_count}), 96'(0));
    #3;
    rst = 1'b1;
    step();
    chk("arst_after", 96'({busy, drop_err, board}), 96'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
